// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
package muldiv_unit_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  funct_t;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  localparam int unsigned DIV_ITERS = 32;
  localparam logic [4:0]  DIV_LAST  = 5'(DIV_ITERS - 1);

  // Low 64 bits of the product of the sign- or zero-extended operands.
  function automatic logic [63:0] mul64(input word_t a, input word_t b, input logic is_signed);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
    eb = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Radix-2 restoring divider on operand magnitudes, one iteration per step.
module div_core
  import muldiv_unit_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  start_i,
  input  logic  step_i,
  input  word_t a_i,
  input  word_t b_i,
  input  logic  is_signed_i,
  output logic  last_o,
  output word_t quo_o,
  output word_t rem_o
);

  word_t      rem_q, rem_d;
  word_t      quo_q, quo_d;
  word_t      dvs_q, dvs_d;
  logic [4:0] cnt_q, cnt_d;
  logic       neg_quo_q, neg_quo_d;
  logic       neg_rem_q, neg_rem_d;

  word_t       a_mag, b_mag;
  logic [32:0] shifted, diff;
  logic        fits;
  word_t       rem_step, quo_step;

  // One restoring iteration plus operand load; results are the post-step values, sign-fixed.
  always_comb begin
    a_mag    = (is_signed_i && a_i[31]) ? -a_i : a_i;
    b_mag    = (is_signed_i && b_i[31]) ? -b_i : b_i;
    shifted  = {rem_q, quo_q[31]};
    diff     = shifted - {1'b0, dvs_q};
    fits     = ~diff[32];
    rem_step = fits ? diff[31:0] : shifted[31:0];
    quo_step = {quo_q[30:0], fits};

    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (start_i) begin
      rem_d     = '0;
      quo_d     = a_mag;
      dvs_d     = b_mag;
      cnt_d     = '0;
      // A zero divisor keeps the all-ones quotient unsigned-looking and hi = a.
      neg_quo_d = is_signed_i && (a_i[31] ^ b_i[31]) && (b_i != '0);
      neg_rem_d = is_signed_i && a_i[31];
    end else if (step_i) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + 5'd1;
    end

    quo_o  = neg_quo_q ? -quo_step : quo_step;
    rem_o  = neg_rem_q ? -rem_step : rem_step;
    last_o = (cnt_q == DIV_LAST);
  end

  // Divider datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: single-cycle registered multiply, 32-cycle restoring divide.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  input  muldiv_op_t req_op,
  input  word_t      req_a,
  input  word_t      req_b,
  output logic       req_ready,
  input  logic       flush,
  output logic       busy,
  output logic       done,
  output word_t      hi,
  output word_t      lo
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  word_t       hi_q, hi_d;
  word_t       lo_q, lo_d;
  logic [63:0] prod_q, prod_d;

  logic  accept;
  logic  div_start, div_step, div_last;
  word_t div_quo, div_rem;

  div_core u_div_core (
    .clk_i       (clk),
    .rst_ni      (resetn),
    .start_i     (div_start),
    .step_i      (div_step),
    .a_i         (req_a),
    .b_i         (req_b),
    .is_signed_i (req_op == MD_DIV),
    .last_o      (div_last),
    .quo_o       (div_quo),
    .rem_o       (div_rem)
  );

  // Handshake and status outputs; reset holds req_ready low.
  always_comb begin
    req_ready = resetn && (state_q == StIdle);
    busy      = (state_q == StMul) || (state_q == StDiv);
    done      = (state_q == StDone);
    accept    = req_valid && req_ready && !flush;
    hi        = hi_q;
    lo        = lo_q;
  end

  // Sequencing FSM and HI/LO next-state.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod_d    = prod_q;
    div_start = 1'b0;
    div_step  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (req_op)
            MD_MULT, MD_MULTU: begin
              prod_d  = mul64(req_a, req_b, req_op == MD_MULT);
              state_d = StMul;
            end
            MD_DIV, MD_DIVU: begin
              div_start = 1'b1;
              state_d   = StDiv;
            end
            MD_MTHI: hi_d = req_a;
            MD_MTLO: lo_d = req_a;
            default: ;
          endcase
        end
      end
      StMul: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          {hi_d, lo_d} = prod_q;
          state_d      = StDone;
        end
      end
      StDiv: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          div_step = 1'b1;
          if (div_last) begin
            hi_d    = div_rem;
            lo_d    = div_quo;
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Architectural state and product register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a behavioural HI/LO model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_valid;
  muldiv_op_t req_op;
  word_t      req_a, req_b;
  logic       req_ready, flush, busy, done;
  word_t      hi, lo;

  word_t hi_m, lo_m;
  int    n_checks = 0;
  int    n_fail = 0;

  muldiv_unit dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(input logic is_s, input word_t a, input word_t b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (is_s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [63:0] ref_div(input logic is_s, input word_t a, input word_t b);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (is_s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {word_t'(r), word_t'(q)};
    end
    return {a % b, a / b};
  endfunction

  function automatic word_t rnd_word();
    word_t specials [5];
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return $urandom_range(0, 20);
      2:       return specials[$urandom_range(0, 4)];
      default: return -word_t'($urandom_range(1, 20));
    endcase
  endfunction

  // Issue one operation from IDLE and follow it to completion.
  task automatic do_op(input muldiv_op_t op, input word_t a, input word_t b);
    int cycles;
    logic [63:0] exp;
    check_eq("ready_idle", 64'(req_ready), 64'd1);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    case (op)
      MD_MTHI, MD_MTLO: begin
        if (op == MD_MTHI) hi_m = a; else lo_m = a;
        check_eq("mt_hi", 64'(hi), 64'(hi_m));
        check_eq("mt_lo", 64'(lo), 64'(lo_m));
        check_eq("mt_busy", 64'(busy), 64'd0);
        check_eq("mt_done", 64'(done), 64'd0);
      end
      MD_MULT, MD_MULTU: begin
        check_eq("mul_busy", 64'(busy), 64'd1);
        req_op = MD_MTLO; req_a = ~lo_m; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        {hi_m, lo_m} = ref_mul(op == MD_MULT, a, b);
        check_eq("mul_hilo", {hi, lo}, {hi_m, lo_m});
        check_eq("mul_done", 64'(done), 64'd1);
        check_eq("mul_busy_done", 64'(busy), 64'd0);
        check_eq("mul_ready_done", 64'(req_ready), 64'd0);
        tick();
        check_eq("mul_done_once", 64'(done), 64'd0);
      end
      default: begin
        check_eq("div_busy", 64'(busy), 64'd1);
        cycles = 0;
        req_op = MD_MTHI; req_a = ~hi_m; req_valid = 1'b1;
        while (busy && cycles < 40) begin
          tick();
          cycles++;
        end
        req_valid = 1'b0;
        exp = ref_div(op == MD_DIV, a, b);
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        check_eq("div_cycles", 64'(cycles), 64'd32);
        check_eq("div_done", 64'(done), 64'd1);
        check_eq("div_hilo", {hi, lo}, {hi_m, lo_m});
        tick();
        check_eq("div_done_once", 64'(done), 64'd0);
      end
    endcase
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; flush = 1'b0;
    req_op = MD_MULT; req_a = '0; req_b = '0;
    hi_m = '0; lo_m = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_ready", 64'(req_ready), 64'd0);
    check_eq("rst_hilo", {hi, lo}, 64'd0);
    resetn = 1'b1;
    tick();
    check_eq("ready_after_rst", 64'(req_ready), 64'd1);

    // Directed cases with literal expectations.
    do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    check_eq("mult_m2x3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op(MD_DIVU, 32'd100, 32'd7);
    check_eq("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    do_op(MD_DIV, -32'sd7, 32'd2);
    check_eq("div_m7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("div_ovf", {hi, lo}, {32'h0, 32'h8000_0000});
    do_op(MD_DIVU, 32'd5, 32'd0);
    check_eq("divu_by0", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd0);
    check_eq("div_by0_neg", {hi, lo}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

    // Flush mid-divide.
    do_op(MD_MTHI, 32'hAAAA_5555, 32'd0);
    do_op(MD_MTLO, 32'h5555_AAAA, 32'd0);
    req_op = MD_DIVU; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (9) tick();
    check_eq("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_busy", 64'(busy), 64'd0);
    check_eq("flush_ready", 64'(req_ready), 64'd1);
    check_eq("flush_hilo", {hi, lo}, {hi_m, lo_m});
    for (int i = 0; i < 3; i++) begin
      check_eq("flush_no_done", 64'(done), 64'd0);
      tick();
    end
    do_op(MD_MTLO, 32'h0BAD_F00D, 32'd0);

    // Flush during multiply.
    req_op = MD_MULTU; req_a = 32'd77; req_b = 32'd99; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("mflush_hilo", {hi, lo}, {hi_m, lo_m});
    check_eq("mflush_done", 64'(done), 64'd0);

    // Flush beats a simultaneous MTHI.
    req_op = MD_MTHI; req_a = 32'h1234_5678; req_valid = 1'b1; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    check_eq("mthi_flush_hi", 64'(hi), 64'(hi_m));

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      do_op(muldiv_op_t'($urandom_range(0, 5)), rnd_word(), rnd_word());
    end

    // Asynchronous reset mid-divide.
    req_op = MD_DIV; req_a = $urandom; req_b = 32'd3; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    #2;
    resetn = 1'b0;
    #1;
    hi_m = '0; lo_m = '0;
    check_eq("arst_hilo", {hi, lo}, 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_ready", 64'(req_ready), 64'd0);
    check_eq("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check_eq("arst_ready_after", 64'(req_ready), 64'd1);
    do_op(MD_DIVU, $urandom, $urandom_range(1, 1000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
